// File: rtl/weight_serial_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : weight_serial_loader
// Description : Bit-serial transmitter for the WeightRAM load link. Takes
//               parallel weight words over a valid/ready handshake and sends
//               each one MSB-first on o_ser_out, with o_we high for exactly
//               WORD_W cycles per word. Loads a frame of NUM_WORDS words, then
//               pulses o_done for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_serial_loader #(
  parameter int WORD_W    = 10,
  parameter int NUM_WORDS = 65,
  parameter int CNT_W     = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_word_in,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_ser_out,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_word_count
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_WORD = 2'd1,
    S_SHIFT     = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // The MSB of the captured word goes straight to the output register, so the
  // shift register only needs to hold the bits still pending.
  logic [WORD_W-2:0] r_shreg;
  logic [WORD_W-2:0] w_shreg_nxt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic [CNT_W-1:0]  r_word_count;
  logic [CNT_W-1:0]  w_word_count_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic              r_ser;
  logic              w_ser_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;

  // Next-state and next-output decode; abort overrides everything below reset.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_word_count_nxt = r_word_count;
    w_we_nxt         = 1'b0;
    w_ser_nxt        = 1'b0;
    w_done_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt      = S_WAIT_WORD;
          w_word_count_nxt = '0;
        end
      end
      S_WAIT_WORD: begin
        if (i_word_valid) begin
          w_state_nxt   = S_SHIFT;
          w_shreg_nxt   = i_word_in[WORD_W-2:0];
          w_bit_cnt_nxt = '0;
          w_we_nxt      = 1'b1;
          w_ser_nxt     = i_word_in[WORD_W-1];
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == c_LAST_BIT) begin
          // Bit 0 finishes on this edge: the word is complete.
          if (r_word_count != c_CNT_FULL) begin
            w_word_count_nxt = r_word_count + 1'b1;
          end
          if (r_word_count == c_CNT_LAST) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_WORD;
          end
        end else begin
          w_we_nxt      = 1'b1;
          w_ser_nxt     = r_shreg[WORD_W-2];
          w_shreg_nxt   = {r_shreg[WORD_W-3:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (i_abort) begin
      w_state_nxt      = S_IDLE;
      w_shreg_nxt      = r_shreg;
      w_bit_cnt_nxt    = '0;
      w_word_count_nxt = r_word_count;
      w_we_nxt         = 1'b0;
      w_ser_nxt        = 1'b0;
      w_done_nxt       = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_word_count <= '0;
      r_we         <= 1'b0;
      r_ser        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_word_count <= w_word_count_nxt;
      r_we         <= w_we_nxt;
      r_ser        <= w_ser_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign o_word_ready = (r_state == S_WAIT_WORD);
  assign o_ser_out    = r_ser;
  assign o_we         = r_we;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_word_count = r_word_count;

endmodule
`default_nettype wire
